// File: rtl/knight_decoder.sv
// Knight-flasher LED bus decoder: locks onto the bouncing one-hot sweep and
// reports position, direction, lock status, mismatch pulses and sweep count.
module knight_decoder #(
  parameter int N  = 8,
  parameter int PW = 3,
  parameter int CW = 8
) (
  input  logic          ck,
  input  logic          res,
  input  logic [N-1:0]  in,
  input  logic          valid,
  output logic [PW-1:0] pos,
  output logic          dir,
  output logic          locked,
  output logic          err,
  output logic [CW-1:0] err_count,
  output logic [CW-1:0] sweeps
);

  typedef enum logic [1:0] {HUNT, ACQ, TRACK} state_t;

  state_t        r_state;
  logic [PW-1:0] r_pos;
  logic          r_dir;
  logic          r_locked;
  logic          r_err;
  logic [CW-1:0] r_err_count;
  logic [CW-1:0] r_sweeps;

  logic          w_seen;
  logic          w_multi;
  logic          w_onehot;
  logic [PW-1:0] w_idx;
  logic [PW:0]   w_up;
  logic [PW:0]   w_dn;
  logic          w_adj_up;
  logic          w_adj_dn;
  logic [PW-1:0] w_exp;
  logic          w_match;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  // Pattern classification: one-hot detection and index of the lit bit
  always_comb begin
    w_seen  = 1'b0;
    w_multi = 1'b0;
    w_idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (in[i]) begin
        if (w_seen) w_multi = 1'b1;
        w_seen = 1'b1;
        w_idx  = PW'(i);
      end
    end
    w_onehot = w_seen & ~w_multi;
  end

  // Neighbour positions are computed one bit wider so pos+1 never aliases
  assign w_up     = {1'b0, r_pos} + (PW+1)'(1);
  assign w_dn     = {1'b0, r_pos} - (PW+1)'(1);
  assign w_adj_up = w_onehot && ({1'b0, w_idx} == w_up);
  assign w_adj_dn = w_onehot && (r_pos != '0) && (w_idx == w_dn[PW-1:0]);
  assign w_exp    = r_dir ? w_up[PW-1:0] : w_dn[PW-1:0];
  assign w_match  = (in == (N'(1) << w_exp));

  always_ff @(posedge ck) begin
    if (res) begin
      r_state     <= HUNT;
      r_pos       <= '0;
      r_dir       <= 1'b1;
      r_locked    <= 1'b0;
      r_err       <= 1'b0;
      r_err_count <= '0;
      r_sweeps    <= '0;
    end else begin
      r_err <= 1'b0;
      if (valid) begin
        case (r_state)
          HUNT: begin
            if (w_onehot) begin
              r_pos   <= w_idx;
              r_state <= ACQ;
            end
          end
          ACQ: begin
            if (!w_onehot) begin
              r_state <= HUNT;
            end else if (w_adj_up) begin
              r_pos    <= w_idx;
              r_dir    <= (w_idx != PW'(N-1));
              r_state  <= TRACK;
              r_locked <= 1'b1;
            end else if (w_adj_dn) begin
              r_pos    <= w_idx;
              r_dir    <= (w_idx == '0);
              r_state  <= TRACK;
              r_locked <= 1'b1;
            end else begin
              r_pos <= w_idx;
            end
          end
          TRACK: begin
            if (w_match) begin
              r_pos <= w_exp;
              if (w_exp == PW'(N-1)) begin
                r_dir <= 1'b0;
              end else if (w_exp == '0) begin
                r_dir    <= 1'b1;
                r_sweeps <= r_sweeps + CW'(1);
              end
            end else begin
              // Any deviation drops lock; pos/dir keep the last good step
              r_err       <= 1'b1;
              r_err_count <= sat_inc(r_err_count);
              r_state     <= HUNT;
              r_locked    <= 1'b0;
            end
          end
          default: begin
            r_state  <= HUNT;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  assign pos       = r_pos;
  assign dir       = r_dir;
  assign locked    = r_locked;
  assign err       = r_err;
  assign err_count = r_err_count;
  assign sweeps    = r_sweeps;

endmodule

// File: tb/tb_knight_decoder.sv
// Self-checking bench for knight_decoder: directed scenarios plus random traffic,
// each sample checked against a behavioural model of the sweep-tracking rules.
module tb_knight_decoder;
  localparam int N  = 8;
  localparam int PW = 3;
  localparam int CW = 8;

  logic          ck = 1'b0;
  logic          res = 1'b0;
  logic [N-1:0]  d_in = '0;
  logic          valid = 1'b0;
  logic [PW-1:0] pos;
  logic          dir;
  logic          locked;
  logic          err;
  logic [CW-1:0] err_count;
  logic [CW-1:0] sweeps;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: mode 0 = searching, 1 = one sighting, 2 = locked
  int m_mode, m_pos, m_dir, m_err, m_ec, m_sw;

  knight_decoder #(.N(N), .PW(PW), .CW(CW)) dut (
    .ck(ck), .res(res), .in(d_in), .valid(valid),
    .pos(pos), .dir(dir), .locked(locked), .err(err),
    .err_count(err_count), .sweeps(sweeps)
  );

  always #5 ck = ~ck;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_update(input logic [N-1:0] v, input bit vl, input bit rs);
    int ones, idx, nxt;
    if (rs) begin
      m_mode = 0; m_pos = 0; m_dir = 1; m_err = 0; m_ec = 0; m_sw = 0;
      return;
    end
    m_err = 0;
    if (!vl) return;
    ones = $countones(v);
    idx = 0;
    for (int i = 0; i < N; i++) if (v[i]) idx = i;
    case (m_mode)
      0: if (ones == 1) begin m_pos = idx; m_mode = 1; end
      1: begin
        if (ones != 1) m_mode = 0;
        else if (idx == m_pos + 1) begin m_dir = (idx < N-1); m_pos = idx; m_mode = 2; end
        else if (idx == m_pos - 1) begin m_dir = (idx == 0); m_pos = idx; m_mode = 2; end
        else m_pos = idx;
      end
      default: begin
        nxt = m_dir ? m_pos + 1 : m_pos - 1;
        if (ones == 1 && idx == nxt) begin
          m_pos = nxt;
          if (nxt == N-1) m_dir = 0;
          if (nxt == 0) begin m_dir = 1; m_sw = (m_sw + 1) % (1 << CW); end
        end else begin
          m_err = 1;
          if (m_ec < (1 << CW) - 1) m_ec++;
          m_mode = 0;
        end
      end
    endcase
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pos"}, 32'(pos), 32'(m_pos));
    check({tag, ".dir"}, 32'(dir), 32'(m_dir));
    check({tag, ".locked"}, 32'(locked), 32'(m_mode == 2));
    check({tag, ".err"}, 32'(err), 32'(m_err));
    check({tag, ".err_count"}, 32'(err_count), 32'(m_ec));
    check({tag, ".sweeps"}, 32'(sweeps), 32'(m_sw));
  endtask

  task automatic step(input string tag, input logic [N-1:0] v, input bit vl, input bit rs);
    d_in = v; valid = vl; res = rs;
    @(posedge ck);
    #1;
    model_update(v, vl, rs);
    check_all(tag);
  endtask

  task automatic do_reset();
    step("reset", $urandom_range(0, 255), 1'b1, 1'b1);
    res = 1'b0;
  endtask

  function automatic logic [N-1:0] sweep_val(input int k);
    int p;
    p = k % (2*N - 2);
    if (p >= N) p = 2*N - 2 - p;
    return N'(1) << p;
  endfunction

  initial begin
    // Reset state
    do_reset();
    check("rst.pos0", 32'(pos), 0);
    check("rst.dir1", 32'(dir), 1);
    check("rst.unlocked", 32'(locked), 0);

    // Clean sweep, three full periods
    for (int k = 0; k <= 42; k++) begin
      step("sweep", sweep_val(k), 1'b1, 1'b0);
      if (k == 0) check("sweep.acq_unlocked", 32'(locked), 0);
      if (k == 1) begin
        check("sweep.lock", 32'(locked), 1);
        check("sweep.lock_pos", 32'(pos), 1);
        check("sweep.lock_dir", 32'(dir), 1);
      end
      if (k == 7) begin
        check("sweep.top_pos", 32'(pos), 7);
        check("sweep.top_dir", 32'(dir), 0);
      end
      if (k == 14) begin
        check("sweep.bot_pos", 32'(pos), 0);
        check("sweep.bot_dir", 32'(dir), 1);
        check("sweep.bot_sweeps", 32'(sweeps), 1);
      end
    end
    check("sweep.total", 32'(sweeps), 3);
    check("sweep.no_errs", 32'(err_count), 0);

    // Mid-sweep acquisition on the down leg
    do_reset();
    for (int p = 5; p >= 0; p--) begin
      step("mid", N'(1) << p, 1'b1, 1'b0);
      if (p == 4) begin
        check("mid.lock", 32'(locked), 1);
        check("mid.pos", 32'(pos), 4);
        check("mid.dir", 32'(dir), 0);
      end
    end
    check("mid.sweeps", 32'(sweeps), 1);

    // Error injection and relock
    do_reset();
    step("inj", 8'h01, 1'b1, 1'b0);
    step("inj", 8'h02, 1'b1, 1'b0);
    step("inj", 8'h04, 1'b1, 1'b0);
    step("inj.bad", 8'h04, 1'b1, 1'b0);
    check("inj.err", 32'(err), 1);
    check("inj.ec", 32'(err_count), 1);
    check("inj.unlock", 32'(locked), 0);
    step("inj", 8'h08, 1'b1, 1'b0);
    check("inj.err_one_cycle", 32'(err), 0);
    step("inj", 8'h10, 1'b1, 1'b0);
    check("inj.relock", 32'(locked), 1);
    check("inj.relock_pos", 32'(pos), 4);
    check("inj.relock_dir", 32'(dir), 1);

    // Invalid patterns and ACQ re-seed
    do_reset();
    step("inv", 8'h01, 1'b1, 1'b0);
    step("inv", 8'h02, 1'b1, 1'b0);
    step("inv.zero", 8'h00, 1'b1, 1'b0);
    check("inv.zero_err", 32'(err), 1);
    step("inv.multi", 8'h03, 1'b1, 1'b0);
    check("inv.multi_noerr", 32'(err), 0);
    check("inv.ec1", 32'(err_count), 1);
    step("inv", 8'h01, 1'b1, 1'b0);
    step("inv.reseed", 8'h08, 1'b1, 1'b0);
    check("inv.reseed_pos", 32'(pos), 3);
    check("inv.reseed_unlocked", 32'(locked), 0);
    step("inv", 8'h10, 1'b1, 1'b0);
    check("inv.lock", 32'(locked), 1);
    check("inv.lock_dir", 32'(dir), 1);

    // valid gating while locked
    for (int i = 0; i < 5; i++) step("gate", N'($urandom), 1'b0, 1'b0);
    check("gate.still_locked", 32'(locked), 1);
    check("gate.pos", 32'(pos), 4);

    // Saturation of err_count
    do_reset();
    for (int i = 0; i < 260; i++) begin
      step("sat", 8'h01, 1'b1, 1'b0);
      step("sat", 8'h02, 1'b1, 1'b0);
      step("sat", 8'h02, 1'b1, 1'b0);
    end
    check("sat.ec", 32'(err_count), 255);

    // Reset mid-operation with err_count=2, sweeps=5
    do_reset();
    for (int k = 0; k <= 70; k++) step("pre", sweep_val(k), 1'b1, 1'b0);
    step("pre", 8'h01, 1'b1, 1'b0);
    step("pre", 8'h02, 1'b1, 1'b0);
    step("pre", 8'h04, 1'b1, 1'b0);
    step("pre", 8'h04, 1'b1, 1'b0);
    step("pre", 8'h02, 1'b1, 1'b0);
    step("pre", 8'h04, 1'b1, 1'b0);
    check("pre.ec", 32'(err_count), 2);
    check("pre.sw", 32'(sweeps), 5);
    check("pre.locked", 32'(locked), 1);
    do_reset();
    check("mrst.ec", 32'(err_count), 0);
    check("mrst.sw", 32'(sweeps), 0);
    check("mrst.locked", 32'(locked), 0);
    step("resume", 8'h08, 1'b1, 1'b0);
    step("resume", 8'h10, 1'b1, 1'b0);
    check("resume.lock", 32'(locked), 1);

    // Random traffic: mostly legal sweep, with glitches, gaps and resets
    begin
      int k;
      logic [N-1:0] v;
      k = $urandom_range(0, 13);
      for (int i = 0; i < 1500; i++) begin
        case ($urandom_range(0, 19))
          0:       v = N'($urandom);
          1, 2:    v = N'(1) << $urandom_range(0, N-1);
          default: begin v = sweep_val(k); k++; end
        endcase
        step("rand", v, ($urandom_range(0, 9) != 0), ($urandom_range(0, 199) == 0));
      end
      res = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/knight_decoder.md
Name: knight_decoder

Overview:
- Receiving end of the knight-flasher LED bus: samples the N-bit sweep pattern, locks onto the bouncing single-lit position, and reports position, direction, lock status, pattern errors and completed sweeps.
- Sits downstream of the flasher, or on a looped-back LED bus, as a self-check and monitor block.
- The legal pattern is one-hot. The lit bit moves up one position per sample until bit N-1, then down one position per sample until bit 0, with no dwell at either end. Period is 2N-2 samples.

Parameters:
- N, 8, LED bus width; must be ≥ 3.
- PW, 3, position width; 2**PW ≥ N.
- CW, 8, width of the error and sweep counters.

Ports:
- ck  in  1  clock; all state updates on the rising edge.
- res  in  1  synchronous, active-high reset.
- in  in  N  LED pattern being decoded.
- valid  in  1  sample strobe; `in` is evaluated only in cycles where valid=1.
- pos  out  PW  index of the lit bit in the last accepted sample.
- dir  out  1  direction of the next expected step: 1 = up (toward N-1), 0 = down.
- locked  out  1  high while the state is TRACK.
- err  out  1  one-cycle pulse on a TRACK mismatch.
- err_count  out  CW  number of mismatches; saturates at all-ones.
- sweeps  out  CW  number of completed full cycles; wraps.

Behaviour:
- Reset (res=1 at a rising edge): state=HUNT, pos=0, dir=1, locked=0, err=0, err_count=0, sweeps=0. res overrides valid.
- Reset mid-operation discards lock and both counters.
- valid=0: all state and outputs hold, except err, which is forced to 0.
- err is 0 in every cycle that does not signal a mismatch.
- All outputs are registered. The effect of a sample taken at edge k is visible after edge k.
- onehot = exactly one bit of `in` set; idx = the index of that bit.
- HUNT, on a valid sample:
  - onehot: pos←idx, go to ACQ.
  - not onehot: stay in HUNT.
  - No err pulse in HUNT.
- ACQ, on a valid sample:
  - onehot and idx=pos+1: dir←1 if idx<N-1, else 0; pos←idx; go to TRACK.
  - onehot and idx=pos-1: dir←0 if idx>0, else 1; pos←idx; go to TRACK.
  - onehot but not adjacent (includes idx=pos): pos←idx, stay in ACQ (re-seed).
  - not onehot: go to HUNT, pos unchanged.
  - No err pulse in ACQ.
- TRACK, expected index:
  - exp = pos+1 if dir=1, else pos-1.
  - dir always points inward at the ends, so exp stays within 0..N-1.
- TRACK, sample matches (`in` = one-hot at exp):
  - pos←exp.
  - If exp=N-1: dir←0.
  - If exp=0: dir←1 and sweeps←sweeps+1 (wraps).
  - Otherwise dir is unchanged.
- TRACK, sample mismatches (anything else, including all-zero, multi-hot, or a repeated position):
  - err←1 for one cycle.
  - err_count←err_count+1, saturating at 2**CW-1.
  - State→HUNT; pos and dir hold their last values.
- locked is 1 exactly when the state is TRACK. It is updated in the same cycle as the state.

Test Plan:
- Clean sweep: reset, then valid=1 with in=01,02,04,…,80,40,…,01,02 (N=8). Expected after each sample:
  - After 01: HUNT→ACQ, locked=0.
  - After 02: locked=1, pos=1, dir=1.
  - After 80: pos=7, dir=0.
  - After the return to 01: pos=0, dir=1, sweeps=1.
  - err never asserts.
  - 3 full periods (42 samples) give sweeps=3, err_count=0.
- Mid-sweep acquisition: first samples 20,10 → locked after 10 with pos=4, dir=0. Continue the sequence; the next bounce at 01 gives sweeps=1.
- Error injection: lock, then feed 04 where 08 is expected → one-cycle err=1, err_count=1, locked=0. Next samples 08,10 → relock with pos=4, dir=1.
- Invalid patterns: in TRACK, feed 00, then 03 → first sample gives err pulse and HUNT. In HUNT, 03 is ignored with no second err; err_count=1. ACQ re-seed: 01 then 08 → stays in ACQ with pos=3; 10 → locks with dir=1.
- valid gating and saturation: with locked=1, hold valid=0 for 5 cycles while `in` toggles garbage → no change, err=0. Then force >2**CW-1 lock/error cycles → err_count sticks at 255.
- Reset mid-operation: in TRACK with err_count=2, sweeps=5, assert res for 1 cycle → pos=0, dir=1, locked=0, err_count=0, sweeps=0. The resumed sweep relocks after 2 valid samples.
